lpm_result_merge: RTL and testbench
===================================

Name: lpm_result_merge

Overview:
Parametrised successor to the router's output-port lookup stage. Buffers the packet stream and pairs each packet's header beat with one externally computed LPM result from a result stream. Rewrites TUSER destination-port bits, exports next-hop and output-queue registers to the ARP stage, and counts misses. Sits between the LPM engine and the ARP/MAC-rewrite stage.

Parameters:
C_AXIS_DATA_WIDTH, 256, stream data width in bits.
C_AXIS_TUSER_WIDTH, 128, TUSER width.
NUM_PORTS, 4, physical ports; each has a CPU twin; 1..4.
SRC_PORT_POS, 16, TUSER LSB of the source-port one-hot field.
DST_PORT_POS, 24, TUSER LSB of the destination-port one-hot field.
FIFO_DEPTH_BITS, 3, log2 of packet-beat FIFO depth.
CNT_WIDTH, 32, counter width.

Ports:
AXI_ACLK  in  1  clock
reset  in  1  synchronous, active-high
S_AXIS_TDATA/TSTRB/TUSER/TVALID/TLAST  in  W/W/8/TU/1/1  ingress stream
S_AXIS_TREADY  out  1  ingress ready
M_AXIS_TDATA/TSTRB/TUSER/TVALID/TLAST  out  W/W/8/TU/1/1  egress stream
M_AXIS_TREADY  in  1  egress ready
res_valid  in  1  LPM result valid
res_ready  out  1  result consumed
res_hit  in  1  LPM hit
res_oq  in  8  output-port index on hit
res_nh  in  32  next-hop IP on hit
clear_counters  in  1  synchronous counter clear
arp_lookup  out  1  last header was a valid hit
nh_reg  out  32  latched next hop
oq_reg  out  8  latched port index
lpm_miss_count  out  CNT_WIDTH  miss counter
pkt_count  out  CNT_WIDTH  headers processed

Behaviour:
- Reset is synchronous, active-high; clock AXI_ACLK. Reset clears the FIFO and puts the FSM in HDR. All outputs are 0 after reset: arp_lookup, nh_reg, oq_reg, counters, res_ready, M_AXIS_TVALID. S_AXIS_TREADY is 1 from the first cycle after reset.
- FIFO: fallthrough, depth 2^FIFO_DEPTH_BITS.
  - S_AXIS_TREADY = !nearly_full (one free slot margin).
  - Write on TVALID&TREADY.
  - Full-FIFO writes are impossible by construction.
- FSM states:
  - HDR: FIFO head is a packet's first beat. M_AXIS_TVALID = !empty & res_valid. On M handshake, res_ready pulses for 1 cycle, so exactly one result is consumed per packet. If the head beat has TLAST, stay in HDR; else go to BODY.
  - BODY: M_AXIS_TVALID = !empty; data passes unmodified. On the handshake of the TLAST beat, go to HDR.
- Header rewrite in HDR (combinational on the output beat):
  - Bypass: if any odd destination bit (DST_PORT_POS+2k+1) is already set, pass TUSER unchanged. The result is still consumed; no counters or registers change except pkt_count.
  - Valid hit: res_hit & res_oq < NUM_PORTS. Destination field = one-hot bit 2*res_oq. On handshake: nh_reg <= res_nh, oq_reg <= res_oq, arp_lookup <= 1.
  - Miss, or res_oq >= NUM_PORTS: destination field = bit 2k+1, where k is the lowest set source bit. lpm_miss_count increments. arp_lookup <= 0; nh_reg and oq_reg hold.
- pkt_count increments on every header handshake.
- Counters wrap at 2^CNT_WIDTH.
- clear_counters zeroes both counters; it wins over a same-cycle increment.
- Simultaneous FIFO write and read is allowed. With M_AXIS_TREADY low, output is stable and nothing is consumed.
- Reset mid-packet: the partial packet is discarded; the next beat accepted is treated as a header.
- Header latency: 0 cycles from res_valid when the beat is already at the FIFO head. From ingress to egress is 1 cycle minimum (fallthrough).

Optional Feature:
Macro LPM_TTL_DEC_EN.
- Defined: on a valid-hit header, TDATA[79:72] (TTL) is decremented and TDATA[63:48] (checksum) is incremented by 1, 16-bit wrap.
  - If TTL <= 1 on a hit, the packet takes the miss path to the CPU with TTL unmodified, and ttl_expired_count (an extra CNT_WIDTH output, same clear rules) increments. lpm_miss_count does not increment.
- Undefined: TDATA is never modified, and the ttl_expired_count port is absent.

Test Plan:
1. 3-beat packet, src bit 0, result hit/oq=2/nh=0x0A000001 -> header TUSER dst=8'b00010000; nh_reg=0x0A000001, oq_reg=2, arp_lookup=1, pkt_count=1.
2. 1-beat packet from src port 3, res_hit=0 -> dst=8'b10000000; lpm_miss_count=1; FSM stays in HDR; res_ready pulses once.
3. Header with dst CPU bit 1 preset, hit result -> TUSER unchanged; nh/oq unchanged; result consumed.
4. Hit with res_oq=5 (NUM_PORTS=4) from src 1 -> dst=8'b00001000; miss count +1.
5. Back-pressure: M_AXIS_TREADY toggles 50% over 20 packets with random res_valid gaps -> no beat lost or duplicated; exactly 20 results consumed; S_AXIS_TREADY drops when FIFO is nearly full.
6. clear_counters asserted in the same cycle as a miss -> lpm_miss_count=0. With LPM_TTL_DEC_EN, a hit with TTL=0x40, csum=0x1234 -> TTL 0x3F, csum 0x1235; a hit with TTL=1 -> CPU port, ttl_expired_count=1.

Source files
------------

// File: rtl/lpm_result_merge.sv
// Buffers the packet stream and merges one LPM result per packet into the header TUSER destination field.
// Optional `LPM_TTL_DEC_EN: TTL decrement and checksum bump on valid hits, adds ttl_expired_count.
module lpm_result_merge #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_PORTS          = 4,
  parameter int SRC_PORT_POS       = 16,
  parameter int DST_PORT_POS       = 24,
  parameter int FIFO_DEPTH_BITS    = 3,
  parameter int CNT_WIDTH          = 32
) (
  input  logic                            AXI_ACLK,
  input  logic                            reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                            S_AXIS_TVALID,
  input  logic                            S_AXIS_TLAST,
  output logic                            S_AXIS_TREADY,
  output logic [C_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                            M_AXIS_TVALID,
  output logic                            M_AXIS_TLAST,
  input  logic                            M_AXIS_TREADY,
  input  logic                            res_valid,
  output logic                            res_ready,
  input  logic                            res_hit,
  input  logic [7:0]                      res_oq,
  input  logic [31:0]                     res_nh,
  input  logic                            clear_counters,
  output logic                            arp_lookup,
  output logic [31:0]                     nh_reg,
  output logic [7:0]                      oq_reg,
  output logic [CNT_WIDTH-1:0]            lpm_miss_count,
  output logic [CNT_WIDTH-1:0]            pkt_count
`ifdef LPM_TTL_DEC_EN
  ,
  output logic [CNT_WIDTH-1:0]            ttl_expired_count
`endif
);

  localparam int DEPTH  = 1 << FIFO_DEPTH_BITS;
  localparam int STRB_W = C_AXIS_DATA_WIDTH / 8;
  localparam int DST_W  = 2 * NUM_PORTS;
  localparam logic [FIFO_DEPTH_BITS:0]   NF_LEVEL   = (FIFO_DEPTH_BITS + 1)'(DEPTH - 1);
  localparam logic [FIFO_DEPTH_BITS:0]   LVL_ONE    = (FIFO_DEPTH_BITS + 1)'(1);
  localparam logic [FIFO_DEPTH_BITS-1:0] PTR_ONE    = FIFO_DEPTH_BITS'(1);
  localparam logic [7:0]                 PORT_LIMIT = 8'(NUM_PORTS);
  localparam logic [CNT_WIDTH-1:0]       CNT_ONE    = CNT_WIDTH'(1);

  typedef struct packed {
    logic [C_AXIS_DATA_WIDTH-1:0]  tdata;
    logic [STRB_W-1:0]             tstrb;
    logic [C_AXIS_TUSER_WIDTH-1:0] tuser;
    logic                          tlast;
  } beat_t;

  typedef enum logic {HDR, BODY} state_t;

  state_t                   state;
  beat_t                    mem [DEPTH];
  beat_t                    wr_beat, head, out_beat;
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_BITS:0]   level;
  logic                     empty, nearly_full, fifo_wr, fifo_rd, hdr_fire;
  logic                     bypass, valid_hit, ttl_ok, take_hit, cpu_found;
  logic [DST_W-1:0]         dst_hit, dst_cpu;

  assign empty         = (level == '0);
  assign nearly_full   = (level >= NF_LEVEL);
  assign S_AXIS_TREADY = !nearly_full;
  assign fifo_wr       = S_AXIS_TVALID && S_AXIS_TREADY;
  assign wr_beat       = {S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TUSER, S_AXIS_TLAST};
  assign head          = mem[rd_ptr];

  // A header may only leave together with its LPM result; body beats need only the FIFO.
  assign M_AXIS_TVALID = !empty && ((state == BODY) || res_valid);
  assign fifo_rd       = M_AXIS_TVALID && M_AXIS_TREADY;
  assign hdr_fire      = (state == HDR) && fifo_rd;
  assign res_ready     = hdr_fire;

  // NOTE: storage is never reset; the pointers and fill level alone decide which entries are live.
  always_ff @(posedge AXI_ACLK) begin
    if (fifo_wr) mem[wr_ptr] <= wr_beat;
  end

  // NOTE: non-blocking assignments make every register here see pre-edge values regardless of statement order.
  always_ff @(posedge AXI_ACLK) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (fifo_rd) rd_ptr <= rd_ptr + PTR_ONE;
      if (fifo_wr && !fifo_rd)      level <= level + LVL_ONE;
      else if (!fifo_wr && fifo_rd) level <= level - LVL_ONE;
    end
  end

  assign valid_hit = res_hit && (res_oq < PORT_LIMIT);
`ifdef LPM_TTL_DEC_EN
  assign ttl_ok = (head.tdata[79:72] > 8'd1);
`else
  assign ttl_ok = 1'b1;
`endif
  assign take_hit = valid_hit && ttl_ok;

  // NOTE: every variable gets a default before any conditional update, so no latch can be inferred.
  always_comb begin
    bypass    = 1'b0;
    dst_hit   = '0;
    dst_cpu   = '0;
    cpu_found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (head.tuser[DST_PORT_POS + 2*k + 1]) bypass = 1'b1;
      if (res_oq == 8'(k)) dst_hit[2*k] = 1'b1;
      // Only the lowest set source bit selects the CPU twin.
      if (!cpu_found && head.tuser[SRC_PORT_POS + k]) begin
        dst_cpu[2*k + 1] = 1'b1;
        cpu_found        = 1'b1;
      end
    end

    out_beat = head;
    if (state == HDR && !bypass) begin
      out_beat.tuser[DST_PORT_POS +: DST_W] = take_hit ? dst_hit : dst_cpu;
`ifdef LPM_TTL_DEC_EN
      if (take_hit) begin
        out_beat.tdata[79:72] = head.tdata[79:72] - 8'd1;
        out_beat.tdata[63:48] = head.tdata[63:48] + 16'd1;
      end
`endif
    end
  end

  assign M_AXIS_TDATA = out_beat.tdata;
  assign M_AXIS_TSTRB = out_beat.tstrb;
  assign M_AXIS_TUSER = out_beat.tuser;
  assign M_AXIS_TLAST = out_beat.tlast;

  always_ff @(posedge AXI_ACLK) begin
    if (reset) begin
      state          <= HDR;
      arp_lookup     <= 1'b0;
      nh_reg         <= '0;
      oq_reg         <= '0;
      lpm_miss_count <= '0;
      pkt_count      <= '0;
`ifdef LPM_TTL_DEC_EN
      ttl_expired_count <= '0;
`endif
    end else begin
      case (state)
        HDR:     if (hdr_fire && !head.tlast) state <= BODY;
        BODY:    if (fifo_rd && head.tlast)   state <= HDR;
        default: state <= HDR;
      endcase

      if (hdr_fire && !bypass) begin
        if (take_hit) begin
          nh_reg     <= res_nh;
          oq_reg     <= res_oq;
          arp_lookup <= 1'b1;
        end else begin
          arp_lookup <= 1'b0;
        end
      end

      // Clearing takes priority over an increment in the same cycle.
      if (clear_counters) begin
        lpm_miss_count <= '0;
        pkt_count      <= '0;
`ifdef LPM_TTL_DEC_EN
        ttl_expired_count <= '0;
`endif
      end else begin
        if (hdr_fire) pkt_count <= pkt_count + CNT_ONE;
        if (hdr_fire && !bypass && !valid_hit) lpm_miss_count <= lpm_miss_count + CNT_ONE;
`ifdef LPM_TTL_DEC_EN
        if (hdr_fire && !bypass && valid_hit && !ttl_ok) ttl_expired_count <= ttl_expired_count + CNT_ONE;
`endif
      end
    end
  end

endmodule

// File: tb/tb_lpm_result_merge.sv
// Self-checking bench for lpm_result_merge: queue-based packet/result model plus directed literal checks.
module tb_lpm_result_merge;
  localparam int W  = 256;
  localparam int SW = W / 8;
  localparam int TU = 128;
  localparam int NP = 4;
  localparam int CW = 32;

  localparam int K_BODY = 0;
  localparam int K_BYP  = 1;
  localparam int K_HIT  = 2;
  localparam int K_MISS = 3;
  localparam int K_TTL  = 4;

  logic          AXI_ACLK = 1'b0;
  logic          reset;
  logic [W-1:0]  S_AXIS_TDATA, M_AXIS_TDATA;
  logic [SW-1:0] S_AXIS_TSTRB, M_AXIS_TSTRB;
  logic [TU-1:0] S_AXIS_TUSER, M_AXIS_TUSER;
  logic          S_AXIS_TVALID, S_AXIS_TLAST, S_AXIS_TREADY;
  logic          M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TREADY;
  logic          res_valid, res_ready, res_hit;
  logic [7:0]    res_oq, oq_reg;
  logic [31:0]   res_nh, nh_reg;
  logic          clear_counters, arp_lookup;
  logic [CW-1:0] lpm_miss_count, pkt_count;
`ifdef LPM_TTL_DEC_EN
  logic [CW-1:0] ttl_expired_count;
  logic [CW-1:0] m_ttl;
`endif

  always #5 AXI_ACLK = ~AXI_ACLK;

  lpm_result_merge dut (
    .AXI_ACLK(AXI_ACLK), .reset(reset),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TSTRB(S_AXIS_TSTRB), .S_AXIS_TUSER(S_AXIS_TUSER),
    .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TREADY(S_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TSTRB(M_AXIS_TSTRB), .M_AXIS_TUSER(M_AXIS_TUSER),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY),
    .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit), .res_oq(res_oq), .res_nh(res_nh),
    .clear_counters(clear_counters), .arp_lookup(arp_lookup), .nh_reg(nh_reg), .oq_reg(oq_reg),
    .lpm_miss_count(lpm_miss_count), .pkt_count(pkt_count)
`ifdef LPM_TTL_DEC_EN
    , .ttl_expired_count(ttl_expired_count)
`endif
  );

  typedef struct packed {
    logic [W-1:0]  d;
    logic [SW-1:0] s;
    logic [TU-1:0] u;
    logic          l;
  } beat_t;
  typedef struct packed {
    logic       hit;
    logic [7:0] oq;
    logic [31:0] nh;
  } res_t;
  typedef struct {
    beat_t       b;
    int          kind;
    logic [31:0] nh;
    logic [7:0]  oq;
  } exp_t;

  beat_t in_q[$];
  res_t  res_q[$];
  exp_t  exp_q[$];

  int total = 0;
  int bad   = 0;
  int pkt_id = 0;
  int rr_cnt = 0;
  int man_req = 0;
  logic chk_en = 1'b0, bp = 1'b0, gaps = 1'b0, res_auto = 1'b1, saw_low = 1'b0;
  logic [7:0]  last_dst, last_ttl;
  logic [15:0] last_csum;
  logic [31:0] m_nh = '0;
  logic [7:0]  m_oq = '0;
  logic        m_arp = 1'b0;
  logic [CW-1:0] m_miss = '0, m_pkt = '0;

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Builds one packet, its result and its expected egress beats straight from the forwarding rules.
  task automatic add_pkt(int nbeats, int src, logic [7:0] dst_pre, logic hit, logic [7:0] oq,
                         logic [31:0] nh, logic [7:0] ttl, logic [15:0] csum);
    beat_t b;
    exp_t  e;
    logic  hit_ok, expired;
    pkt_id++;
    for (int i = 0; i < nbeats; i++) begin
      for (int j = 0; j < W / 32; j++) b.d[j*32 +: 32] = $urandom();
      for (int j = 0; j < TU / 32; j++) b.u[j*32 +: 32] = $urandom();
      b.d[7:0]  = 8'(pkt_id);
      b.d[15:8] = 8'(i);
      b.s = $urandom();
      b.l = (i == nbeats - 1);
      e.kind = K_BODY;
      e.nh = nh;
      e.oq = oq;
      if (i == 0) begin
        b.d[79:72] = ttl;
        b.d[63:48] = csum;
        b.u[16 +: 8] = 8'(1 << src);
        b.u[24 +: 8] = dst_pre;
      end
      e.b = b;
      if (i == 0) begin
        hit_ok  = hit && (oq < 8'(NP));
        expired = 1'b0;
`ifdef LPM_TTL_DEC_EN
        if (hit_ok && ttl <= 8'd1) begin
          hit_ok  = 1'b0;
          expired = 1'b1;
        end
`endif
        if ((dst_pre & 8'hAA) != 8'h00) begin
          e.kind = K_BYP;
        end else if (hit_ok) begin
          e.kind = K_HIT;
          e.b.u[24 +: 8] = 8'(1 << (2 * oq));
`ifdef LPM_TTL_DEC_EN
          e.b.d[79:72] = ttl - 8'd1;
          e.b.d[63:48] = csum + 16'd1;
`endif
        end else begin
          e.kind = expired ? K_TTL : K_MISS;
          e.b.u[24 +: 8] = 8'(1 << (2 * src + 1));
        end
      end
      in_q.push_back(b);
      exp_q.push_back(e);
    end
    res_q.push_back({hit, oq, nh});
  endtask

  task automatic wait_idle(string name);
    int c = 0;
    while ((exp_q.size() != 0 || in_q.size() != 0) && c < 3000) begin
      @(negedge AXI_ACLK);
      c++;
    end
    check({name, "_drained"}, W'(exp_q.size()), '0);
    repeat (2) @(negedge AXI_ACLK);
  endtask

  initial begin : ingress
    beat_t b;
    logic  s_acc;
    S_AXIS_TVALID = 1'b0; S_AXIS_TDATA = '0; S_AXIS_TSTRB = '0; S_AXIS_TUSER = '0; S_AXIS_TLAST = 1'b0;
    forever begin
      @(negedge AXI_ACLK);
      s_acc = S_AXIS_TVALID && S_AXIS_TREADY;
      if (S_AXIS_TREADY === 1'b0) saw_low = 1'b1;
      @(posedge AXI_ACLK);
      #1;
      if (s_acc || !S_AXIS_TVALID) begin
        if (in_q.size() > 0) begin
          b = in_q.pop_front();
          S_AXIS_TDATA = b.d; S_AXIS_TSTRB = b.s; S_AXIS_TUSER = b.u; S_AXIS_TLAST = b.l;
          S_AXIS_TVALID = 1'b1;
        end else begin
          S_AXIS_TVALID = 1'b0;
        end
      end
    end
  end

  initial begin : result_drv
    res_t r;
    logic r_acc;
    int   man_done = 0;
    res_valid = 1'b0; res_hit = 1'b0; res_oq = '0; res_nh = '0;
    forever begin
      @(negedge AXI_ACLK);
      r_acc = res_valid && res_ready;
      @(posedge AXI_ACLK);
      #1;
      if (!res_auto) begin
        if (man_req != man_done && res_q.size() > 0) begin
          r = res_q.pop_front();
          res_valid = 1'b1; res_hit = r.hit; res_oq = r.oq; res_nh = r.nh;
          man_done++;
        end else begin
          res_valid = 1'b0;
        end
      end else if (r_acc || !res_valid) begin
        if (res_q.size() > 0 && (!gaps || $urandom_range(0, 2) == 0)) begin
          r = res_q.pop_front();
          res_valid = 1'b1; res_hit = r.hit; res_oq = r.oq; res_nh = r.nh;
        end else begin
          res_valid = 1'b0;
        end
      end
    end
  end

  initial begin : sink
    M_AXIS_TREADY = 1'b1;
    forever begin
      @(posedge AXI_ACLK);
      #1;
      M_AXIS_TREADY = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process: registers against the model every cycle, egress beats at every handshake.
  always @(negedge AXI_ACLK) begin : compare
    exp_t e;
    if (res_valid && res_ready) rr_cnt++;
    if (chk_en) begin
      check("arp_lookup", W'(arp_lookup), W'(m_arp));
      check("nh_reg", W'(nh_reg), W'(m_nh));
      check("oq_reg", W'(oq_reg), W'(m_oq));
      check("lpm_miss_count", W'(lpm_miss_count), W'(m_miss));
      check("pkt_count", W'(pkt_count), W'(m_pkt));
`ifdef LPM_TTL_DEC_EN
      check("ttl_expired_count", W'(ttl_expired_count), W'(m_ttl));
`endif
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", W'(1), W'(0));
        end else begin
          e = exp_q.pop_front();
          check("tdata", M_AXIS_TDATA, e.b.d);
          check("tuser", W'(M_AXIS_TUSER), W'(e.b.u));
          check("tstrb", W'(M_AXIS_TSTRB), W'(e.b.s));
          check("tlast", W'(M_AXIS_TLAST), W'(e.b.l));
          check("res_ready_on_beat", W'(res_ready), W'(e.kind != K_BODY));
          if (e.kind != K_BODY) begin
            check("res_valid_at_hdr", W'(res_valid), W'(1));
            last_dst  = M_AXIS_TUSER[31:24];
            last_ttl  = M_AXIS_TDATA[79:72];
            last_csum = M_AXIS_TDATA[63:48];
            m_pkt++;
            if (e.kind == K_HIT) begin
              m_nh = e.nh; m_oq = e.oq; m_arp = 1'b1;
            end else if (e.kind == K_MISS) begin
              m_arp = 1'b0; m_miss++;
            end else if (e.kind == K_TTL) begin
              m_arp = 1'b0;
`ifdef LPM_TTL_DEC_EN
              m_ttl++;
`endif
            end
          end
        end
      end else begin
        check("res_ready_idle", W'(res_ready), W'(0));
      end
      if (clear_counters) begin
        m_miss = '0;
        m_pkt  = '0;
`ifdef LPM_TTL_DEC_EN
        m_ttl  = '0;
`endif
      end
    end
  end

  initial begin : watchdog
    #500000;
    check("watchdog_time_limit", W'(1), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : main
    int rr0;
    reset = 1'b1;
    clear_counters = 1'b0;
    repeat (3) @(posedge AXI_ACLK);
    #1 reset = 1'b0;
    @(negedge AXI_ACLK);
    check("rst_arp", W'(arp_lookup), '0);
    check("rst_nh", W'(nh_reg), '0);
    check("rst_oq", W'(oq_reg), '0);
    check("rst_miss", W'(lpm_miss_count), '0);
    check("rst_pkt", W'(pkt_count), '0);
    check("rst_res_ready", W'(res_ready), '0);
    check("rst_m_tvalid", W'(M_AXIS_TVALID), '0);
    check("rst_s_tready", W'(S_AXIS_TREADY), W'(1));
    chk_en = 1'b1;

    // 1: three-beat hit
    add_pkt(3, 0, 8'h00, 1'b1, 8'd2, 32'h0A000001, 8'h40, 16'h1234);
    wait_idle("t1");
    check("t1_dst", W'(last_dst), W'(8'b0001_0000));
    check("t1_nh", W'(nh_reg), W'(32'h0A000001));
    check("t1_oq", W'(oq_reg), W'(2));
    check("t1_arp", W'(arp_lookup), W'(1));
    check("t1_pkt", W'(pkt_count), W'(1));

    // 2: single-beat miss from source 3
    rr0 = rr_cnt;
    add_pkt(1, 3, 8'h00, 1'b0, 8'd0, 32'h0, 8'h40, 16'h0);
    wait_idle("t2");
    check("t2_dst", W'(last_dst), W'(8'b1000_0000));
    check("t2_miss", W'(lpm_miss_count), W'(1));
    check("t2_arp", W'(arp_lookup), W'(0));
    check("t2_res_once", W'(rr_cnt - rr0), W'(1));

    // 3: CPU bit preset, passes through untouched
    rr0 = rr_cnt;
    add_pkt(2, 0, 8'b0000_0010, 1'b1, 8'd1, 32'hDEADBEEF, 8'h40, 16'h0);
    wait_idle("t3");
    check("t3_dst", W'(last_dst), W'(8'b0000_0010));
    check("t3_nh", W'(nh_reg), W'(32'h0A000001));
    check("t3_oq", W'(oq_reg), W'(2));
    check("t3_res_once", W'(rr_cnt - rr0), W'(1));
    check("t3_pkt", W'(pkt_count), W'(3));

    // 4: hit with out-of-range port index from source 1
    add_pkt(2, 1, 8'h00, 1'b1, 8'd5, 32'h11111111, 8'h40, 16'h0);
    wait_idle("t4");
    check("t4_dst", W'(last_dst), W'(8'b0000_1000));
    check("t4_miss", W'(lpm_miss_count), W'(2));

    // 5: back-pressure and result gaps over 20 packets
    bp = 1'b1; gaps = 1'b1; saw_low = 1'b0; rr0 = rr_cnt;
    for (int i = 0; i < 20; i++)
      add_pkt(int'($urandom_range(1, 5)), int'($urandom_range(0, 3)),
              ($urandom_range(0, 4) == 0) ? 8'h08 : 8'h00, 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 5)), $urandom(),
              ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h40, 16'($urandom()));
    wait_idle("t5");
    check("t5_results", W'(rr_cnt - rr0), W'(20));
    check("t5_tready_dropped", W'(saw_low), W'(1));
    bp = 1'b0; gaps = 1'b0;

    // 6: clear in the same cycle as a miss header
    res_auto = 1'b0;
    add_pkt(1, 2, 8'h00, 1'b0, 8'd0, 32'h0, 8'h40, 16'h0);
    repeat (4) @(negedge AXI_ACLK);
    man_req++;
    @(posedge AXI_ACLK);
    #1 clear_counters = 1'b1;
    @(posedge AXI_ACLK);
    #1 clear_counters = 1'b0;
    wait_idle("t6");
    res_auto = 1'b1;
    check("t6_dst", W'(last_dst), W'(8'b0010_0000));
    check("t6_miss_cleared", W'(lpm_miss_count), '0);
    check("t6_pkt_cleared", W'(pkt_count), '0);

`ifdef LPM_TTL_DEC_EN
    add_pkt(2, 0, 8'h00, 1'b1, 8'd3, 32'h01020304, 8'h40, 16'h1234);
    wait_idle("ttl_a");
    check("ttl_a_ttl", W'(last_ttl), W'(8'h3F));
    check("ttl_a_csum", W'(last_csum), W'(16'h1235));
    check("ttl_a_dst", W'(last_dst), W'(8'b0100_0000));
    add_pkt(1, 0, 8'h00, 1'b1, 8'd1, 32'h05060708, 8'h01, 16'h0);
    wait_idle("ttl_b");
    check("ttl_b_dst", W'(last_dst), W'(8'b0000_0010));
    check("ttl_b_ttl", W'(last_ttl), W'(8'h01));
    check("ttl_b_expired", W'(ttl_expired_count), W'(1));
    check("ttl_b_miss", W'(lpm_miss_count), '0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
